m68020_bus_responder: RTL and testbench
=======================================

Name: m68020_bus_responder

Overview:
- Slave/responder end of the 68020 asynchronous bus. Decodes an address window and turns CPU cycles (nAS/nDS/RnW/SIZ/A) into single-request transfers on a simple synchronous memory port.
- Terminates each cycle with 32-bit-port nDSACK, or with nBERR on timeout.
- Sits between the CPU bus model and on-chip RAM or peripherals.

Parameters:
- BASE_ADDR, 32'h0000_0000: window base address; match when (A & ADDR_MASK) == BASE_ADDR.
- ADDR_MASK, 32'hFFF0_0000: window decode mask.
- TIMEOUT, 16: CLK cycles MEM_REQ may remain unacknowledged before nBERR is asserted.

Ports:
- CLK  input  1  bus clock; all logic on rising edge.
- nRESET  input  1  asynchronous, active-low reset.
- FC  input  3  function code; 3'b111 (CPU space) never matches.
- A  input  32  address.
- SIZ  input  2  transfer size: 01 byte, 10 word, 11 three-byte, 00 long.
- RnW  input  1  1 = read.
- nAS  input  1  address strobe, asynchronous.
- nDS  input  1  data strobe, asynchronous.
- D_I  input  32  data from CPU (write).
- D_O  output  32  data to CPU (read).
- D_OE  output  1  data bus drive enable.
- nDSACK  output  2  termination; 2'b00 = 32-bit ack, 2'b11 = idle/wait.
- nBERR  output  1  bus error, active low.
- MEM_REQ  output  1  request, held until MEM_ACK.
- MEM_WE  output  1  1 = write.
- MEM_ADDR  output  30  longword address A[31:2].
- MEM_BE  output  4  byte enables; BE[3] = D[31:24].
- MEM_WDATA  output  32  write data.
- MEM_ACK  input  1  one-cycle completion pulse.
- MEM_RDATA  input  32  read data, valid with MEM_ACK.

Behaviour:
- Reset (async, any state): nDSACK=2'b11, nBERR=1, D_OE=0, D_O=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_BE=0, MEM_WDATA=0, state IDLE.
- nAS and nDS each pass through a 2-FF synchronizer (as_s, ds_s). A, FC, SIZ and RnW are sampled when as_s is first seen low.
- States: IDLE, SKIP, WAITDS, ACCESS, ACK, BERR.
  - IDLE: on as_s low with a window match and FC != 3'b111: read -> ACCESS; write -> WAITDS. On as_s low without a match -> SKIP.
  - SKIP: all outputs idle until as_s high, then IDLE.
  - WAITDS: when ds_s is low, latch D_I into MEM_WDATA, then ACCESS.
  - ACCESS: MEM_REQ=1; MEM_WE=!RnW; MEM_ADDR/MEM_BE driven from the latched values; timeout counter counts.
    - MEM_ACK=1 -> ACK. On a read, MEM_RDATA is latched to D_O.
    - Counter reaches TIMEOUT without MEM_ACK -> BERR.
    - MEM_ACK in the same cycle as timeout expiry: ACK wins.
    - MEM_REQ drops in the cycle after MEM_ACK or expiry.
  - ACK: nDSACK=2'b00. On a read, D_OE=1 while ds_s is low. Hold until as_s high, then: nDSACK=2'b11, D_OE=0, -> IDLE (one-cycle registered update).
  - BERR: nBERR=0, nDSACK=2'b11. Hold until as_s high, then nBERR=1, -> IDLE.
- Byte enables (32-bit port, big-endian), with off = A[1:0] and n = SIZ (00 means 4):
  - Lanes off .. min(3, off+n-1) are enabled; lane k maps to BE[3-k].
  - Misaligned remainder is not transferred in this cycle; the CPU issues it as a follow-up cycle.
- Latency: nAS low to MEM_REQ is 3 CLK for a read. A zero-wait memory gives nDSACK low 2 CLK after MEM_REQ.
- nAS negating mid-ACCESS (aborted cycle): the cycle completes on the memory side; ACK/BERR then exit immediately because as_s is already high.
- Back-to-back cycles: a new cycle is never accepted before IDLE, so nAS must be seen high for at least one synchronized sample.

Test Plan:
- Long write: A=32'h0000_0010, SIZ=00, D_I=32'hDEADBEEF -> MEM_WE=1, MEM_ADDR=30'h4, MEM_BE=4'b1111, MEM_WDATA=32'hDEADBEEF; nDSACK=2'b00 until nAS high, then 2'b11.
- Byte read: A=32'h0000_0003, SIZ=01, MEM_RDATA=32'h112233AA -> MEM_BE=4'b0001, D_O=32'h112233AA, D_OE=1 only while nDS low, nDSACK=2'b00.
- Misaligned word: A=32'h0000_0003, SIZ=10 -> MEM_BE=4'b0001; three-byte at A=1, SIZ=11 -> MEM_BE=4'b0111.
- Timeout: MEM_ACK held 0 -> nBERR low exactly TIMEOUT cycles after MEM_REQ rose; MEM_REQ drops; nDSACK stays 2'b11; nBERR releases after nAS high.
- Decode miss: A=32'h0100_0000, and separately FC=3'b111 inside the window -> no MEM_REQ, nDSACK=2'b11, nBERR=1 throughout.
- Reset mid-ACK: nRESET low while nDSACK=2'b00 -> nDSACK=2'b11, D_OE=0, MEM_REQ=0 immediately, without waiting for CLK; a new cycle after release completes normally.

Source files
------------

// File: rtl/m68020_bus_responder.sv
// 68020 asynchronous-bus slave: decodes an address window and converts each CPU
// cycle into one request on a synchronous memory port, ending it with nDSACK or nBERR.
module m68020_bus_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFF0_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [2:0]  FC,
    input  logic [31:0] A,
    input  logic [1:0]  SIZ,
    input  logic        RnW,
    input  logic        nAS,
    input  logic        nDS,
    input  logic [31:0] D_I,
    output logic [31:0] D_O,
    output logic        D_OE,
    output logic [1:0]  nDSACK,
    output logic        nBERR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [29:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SKIP, WAITDS, ACCESS, ACK, BERR} state_t;

    // Big-endian lanes off..off+n-1 (clipped at lane 3) on a 32-bit port; lane k is BE[3-k].
    function automatic logic [3:0] byteEnables(input logic [1:0] off, input logic [1:0] siz);
        logic [2:0] n;
        logic [2:0] last;
        n    = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
        last = {1'b0, off} + n - 3'd1;
        return (4'b1111 >> off) & ~(4'b1111 >> (last + 3'd1));
    endfunction

    state_t           state;
    logic             asMeta, asSync, dsMeta, dsSync;
    logic             latRnW;
    logic [29:0]      latAddr;
    logic [3:0]       latBe;
    logic [CNT_W-1:0] toCnt;
    logic             hit;
    logic [3:0]       beNow;

    assign hit   = ((A & ADDR_MASK) == BASE_ADDR) && (FC != 3'b111);
    assign beNow = byteEnables(A[1:0], SIZ);

    // Strobe synchronizers, bus-cycle FSM and all registered outputs.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            asMeta    <= 1'b1;
            asSync    <= 1'b1;
            dsMeta    <= 1'b1;
            dsSync    <= 1'b1;
            state     <= IDLE;
            latRnW    <= 1'b1;
            latAddr   <= 30'd0;
            latBe     <= 4'd0;
            toCnt     <= '0;
            nDSACK    <= 2'b11;
            nBERR     <= 1'b1;
            D_OE      <= 1'b0;
            D_O       <= 32'd0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= 30'd0;
            MEM_BE    <= 4'd0;
            MEM_WDATA <= 32'd0;
        end else begin
            asMeta <= nAS;
            asSync <= asMeta;
            dsMeta <= nDS;
            dsSync <= dsMeta;
            case (state)
                IDLE: begin
                    if (!asSync) begin
                        latRnW  <= RnW;
                        latAddr <= A[31:2];
                        latBe   <= beNow;
                        if (hit && RnW) begin
                            MEM_REQ  <= 1'b1;
                            MEM_WE   <= 1'b0;
                            MEM_ADDR <= A[31:2];
                            MEM_BE   <= beNow;
                            toCnt    <= '0;
                            state    <= ACCESS;
                        end else if (hit) begin
                            state <= WAITDS;
                        end else begin
                            state <= SKIP;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SKIP: begin
                    state <= asSync ? IDLE : SKIP;
                end
                WAITDS: begin
                    if (!dsSync) begin
                        MEM_WDATA <= D_I;
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= 1'b1;
                        MEM_ADDR  <= latAddr;
                        MEM_BE    <= latBe;
                        toCnt     <= '0;
                        state     <= ACCESS;
                    end else if (asSync) begin
                        // Write abandoned before its data strobe: nothing to transfer.
                        state <= IDLE;
                    end else begin
                        state <= WAITDS;
                    end
                end
                ACCESS: begin
                    // A late acknowledge coinciding with expiry still completes normally.
                    if (MEM_ACK) begin
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        nDSACK  <= 2'b00;
                        if (latRnW) begin
                            D_O  <= MEM_RDATA;
                            D_OE <= !dsSync;
                        end else begin
                            D_OE <= 1'b0;
                        end
                        state <= ACK;
                    end else if (toCnt == CNT_LAST) begin
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        nBERR   <= 1'b0;
                        state   <= BERR;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                ACK: begin
                    if (asSync) begin
                        nDSACK <= 2'b11;
                        D_OE   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        D_OE <= latRnW && !dsSync;
                    end
                end
                BERR: begin
                    if (asSync) begin
                        nBERR <= 1'b1;
                        state <= IDLE;
                    end else begin
                        nBERR <= 1'b0;
                    end
                end
                default: begin
                    nDSACK  <= 2'b11;
                    nBERR   <= 1'b1;
                    D_OE    <= 1'b0;
                    MEM_REQ <= 1'b0;
                    MEM_WE  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68020_bus_responder.sv
// Directed bench for m68020_bus_responder: table of bus cycles against a
// parameterised-latency memory model, plus timeout and reset-in-ACK sequences.
module tb_m68020_bus_responder;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic [2:0]  FC;
    logic [31:0] A;
    logic [1:0]  SIZ;
    logic        RnW;
    logic        nAS;
    logic        nDS;
    logic [31:0] D_I;
    logic [31:0] D_O;
    logic        D_OE;
    logic [1:0]  nDSACK;
    logic        nBERR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [29:0] MEM_ADDR;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;

    int          checks = 0;
    int          errors = 0;
    int          memWait = 0;
    logic        memEnable = 1'b1;
    logic [31:0] memRdata = 32'd0;
    int          waitCnt = 0;

    always #5 CLK = ~CLK;

    m68020_bus_responder dut (
        .CLK(CLK), .nRESET(nRESET), .FC(FC), .A(A), .SIZ(SIZ), .RnW(RnW),
        .nAS(nAS), .nDS(nDS), .D_I(D_I), .D_O(D_O), .D_OE(D_OE),
        .nDSACK(nDSACK), .nBERR(nBERR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
    );

    // Memory: acknowledges memWait+1 edges after it first sees MEM_REQ.
    always_ff @(posedge CLK) begin
        if (!MEM_REQ || MEM_ACK) begin
            waitCnt <= 0;
            MEM_ACK <= 1'b0;
        end else if (memEnable && waitCnt == memWait) begin
            MEM_ACK   <= 1'b1;
            MEM_RDATA <= memRdata;
        end else begin
            waitCnt <= waitCnt + 1;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [1:0]  siz;
        logic        rnw;
        logic [2:0]  fc;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_;
        logic        hit;
        logic [3:0]  be;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runCycle(input vec_t v, input int idx);
        int reqAt, ackAt, relAt;
        logic sawBerr;
        logic [3:0] be;
        logic [29:0] addr;
        logic we;
        logic [31:0] wd;
        string tag;
        tag = $sformatf("v%0d", idx);
        be = 4'd0; addr = 30'd0; we = 1'b0; wd = 32'd0;
        @(negedge CLK);
        memWait = v.wait_;
        memRdata = v.rdata;
        FC = v.fc; A = v.a; SIZ = v.siz; RnW = v.rnw; D_I = v.wdata;
        nAS = 1'b0; nDS = 1'b0;
        reqAt = -1; ackAt = -1; sawBerr = 1'b0;
        for (int n = 1; n <= 40 && ackAt < 0; n++) begin
            @(negedge CLK);
            if (MEM_REQ && reqAt < 0) begin
                reqAt = n; be = MEM_BE; addr = MEM_ADDR; we = MEM_WE; wd = MEM_WDATA;
            end
            if (nDSACK == 2'b00) ackAt = n;
            if (!nBERR) sawBerr = 1'b1;
        end
        check({tag, "_berr"}, {31'd0, sawBerr}, 32'd0);
        if (v.hit) begin
            check({tag, "_req_lat"}, reqAt, v.rnw ? 3 : 4);
            check({tag, "_ack_lat"}, ackAt - reqAt, v.wait_ + 2);
            check({tag, "_be"}, {28'd0, be}, {28'd0, v.be});
            check({tag, "_addr"}, {2'd0, addr}, {2'd0, v.a[31:2]});
            check({tag, "_we"}, {31'd0, we}, {31'd0, ~v.rnw});
            if (!v.rnw) check({tag, "_wdata"}, wd, v.wdata);
            check({tag, "_req_drop"}, {31'd0, MEM_REQ}, 32'd0);
            if (v.rnw) begin
                check({tag, "_dout"}, D_O, v.rdata);
                check({tag, "_doe_ds"}, {31'd0, D_OE}, 32'd1);
            end
            @(negedge CLK);
            nDS = 1'b1;
            repeat (3) @(negedge CLK);
            check({tag, "_doe_off"}, {31'd0, D_OE}, 32'd0);
            check({tag, "_dsack_hold"}, {30'd0, nDSACK}, 32'd0);
            nAS = 1'b1;
            relAt = -1;
            for (int n = 1; n <= 6 && relAt < 0; n++) begin
                @(negedge CLK);
                if (nDSACK == 2'b11) relAt = n;
            end
            check({tag, "_dsack_release"}, relAt, 3);
        end else begin
            check({tag, "_no_req"}, reqAt, -1);
            check({tag, "_no_ack"}, ackAt, -1);
            nAS = 1'b1; nDS = 1'b1;
            repeat (4) @(negedge CLK);
            check({tag, "_dsack_idle"}, {30'd0, nDSACK}, 32'd3);
        end
        nAS = 1'b1; nDS = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int reqAt, berrAt, ackAt, relAt;
        logic reqAtBerr;
        logic [1:0] dsackAtBerr;

        vecs[0] = '{32'h0000_0010, 2'b00, 1'b0, 3'b101, 32'hDEAD_BEEF, 32'h0, 0, 1'b1, 4'b1111};
        vecs[1] = '{32'h0000_0003, 2'b01, 1'b1, 3'b101, 32'h0, 32'h1122_33AA, 0, 1'b1, 4'b0001};
        vecs[2] = '{32'h0000_0003, 2'b10, 1'b1, 3'b001, 32'h0, 32'h5566_7788, 0, 1'b1, 4'b0001};
        vecs[3] = '{32'h0000_0001, 2'b11, 1'b0, 3'b001, 32'h0A0B_0C0D, 32'h0, 0, 1'b1, 4'b0111};
        vecs[4] = '{32'h000F_FFFE, 2'b10, 1'b0, 3'b101, 32'h1234_5678, 32'h0, 2, 1'b1, 4'b0011};
        vecs[5] = '{32'h0100_0000, 2'b00, 1'b1, 3'b101, 32'h0, 32'h0, 0, 1'b0, 4'b0000};
        vecs[6] = '{32'h0000_0020, 2'b00, 1'b1, 3'b111, 32'h0, 32'h0, 0, 1'b0, 4'b0000};
        vecs[7] = '{32'h0004_0008, 2'b00, 1'b1, 3'b101, 32'h0, 32'hCAFE_F00D, 0, 1'b1, 4'b1111};
        vecs[8] = '{32'h0000_0042, 2'b01, 1'b1, 3'b101, 32'h0, 32'h1357_9BDF, 14, 1'b1, 4'b0010};

        nRESET = 1'b0; FC = 3'b000; A = 32'd0; SIZ = 2'b00; RnW = 1'b1;
        nAS = 1'b1; nDS = 1'b1; D_I = 32'd0;
        repeat (3) @(negedge CLK);
        check("rst_dsack", {30'd0, nDSACK}, 32'd3);
        check("rst_berr", {31'd0, nBERR}, 32'd1);
        check("rst_doe", {31'd0, D_OE}, 32'd0);
        check("rst_dout", D_O, 32'd0);
        check("rst_req", {31'd0, MEM_REQ}, 32'd0);
        check("rst_we", {31'd0, MEM_WE}, 32'd0);
        check("rst_addr", {2'd0, MEM_ADDR}, 32'd0);
        check("rst_be", {28'd0, MEM_BE}, 32'd0);
        check("rst_wdata", MEM_WDATA, 32'd0);
        nRESET = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 9; i++) runCycle(vecs[i], i);

        // Timeout: memory never answers.
        memEnable = 1'b0;
        @(negedge CLK);
        FC = 3'b101; A = 32'h0000_0040; SIZ = 2'b00; RnW = 1'b1; nAS = 1'b0; nDS = 1'b0;
        reqAt = -1; berrAt = -1; ackAt = -1; reqAtBerr = 1'b1; dsackAtBerr = 2'b00;
        for (int n = 1; n <= 60 && berrAt < 0; n++) begin
            @(negedge CLK);
            if (MEM_REQ && reqAt < 0) reqAt = n;
            if (nDSACK == 2'b00) ackAt = n;
            if (!nBERR) begin
                berrAt = n; reqAtBerr = MEM_REQ; dsackAtBerr = nDSACK;
            end
        end
        check("to_berr_lat", berrAt - reqAt, 16);
        check("to_req_drop", {31'd0, reqAtBerr}, 32'd0);
        check("to_dsack", {30'd0, dsackAtBerr}, 32'd3);
        check("to_no_ack", ackAt, -1);
        repeat (3) @(negedge CLK);
        check("to_berr_hold", {31'd0, nBERR}, 32'd0);
        nAS = 1'b1; nDS = 1'b1;
        relAt = -1;
        for (int n = 1; n <= 6 && relAt < 0; n++) begin
            @(negedge CLK);
            if (nBERR) relAt = n;
        end
        check("to_berr_release", relAt, 3);
        memEnable = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset asserted while the cycle is being acknowledged.
        memWait = 0; memRdata = 32'hA5A5_5A5A;
        FC = 3'b101; A = 32'h0000_0100; SIZ = 2'b00; RnW = 1'b1; nAS = 1'b0; nDS = 1'b0;
        ackAt = -1;
        for (int n = 1; n <= 20 && ackAt < 0; n++) begin
            @(negedge CLK);
            if (nDSACK == 2'b00) ackAt = n;
        end
        check("rack_reached", ackAt, 5);
        nRESET = 1'b0;
        #1;
        check("rack_dsack", {30'd0, nDSACK}, 32'd3);
        check("rack_doe", {31'd0, D_OE}, 32'd0);
        check("rack_req", {31'd0, MEM_REQ}, 32'd0);
        nAS = 1'b1; nDS = 1'b1;
        @(negedge CLK);
        nRESET = 1'b1;
        repeat (3) @(negedge CLK);
        runCycle(vecs[7], 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
